// File: rtl/sarray_left_feeder_if.sv
// sarray_left_feeder_if: command, column-beat and skewed left-edge bundle for sarray_left_feeder
// master = producer of commands/beats and consumer of lanes; slave = the feeder itself.
// cmd_*: tile command handshake; in_*: column-beat handshake; left_in_*: per-lane skewed outputs;
// busy_o/done_o: tile status.
interface sarray_left_feeder_if #(
    parameter int H      = 64,
    parameter int DW     = 16,
    parameter int CNT_W  = 8,
    parameter int PREC_W = 2
);
    logic                  cmd_valid_i;
    logic                  cmd_ready_o;
    logic [CNT_W-1:0]      cmd_len_i;
    logic                  cmd_type_i;
    logic [PREC_W-1:0]     cmd_precision_i;
    logic                  in_valid_i;
    logic                  in_ready_o;
    logic [H*DW-1:0]       in_data_i;
    logic [H-1:0]          left_in_valid_o;
    logic [H*CNT_W-1:0]    left_in_cnt_o;
    logic [H-1:0]          left_in_type_o;
    logic [H*PREC_W-1:0]   left_in_precision_o;
    logic [H*DW-1:0]       left_in_data_o;
    logic                  busy_o;
    logic                  done_o;

    modport master (
        output cmd_valid_i, cmd_len_i, cmd_type_i, cmd_precision_i, in_valid_i, in_data_i,
        input  cmd_ready_o, in_ready_o, left_in_valid_o, left_in_cnt_o, left_in_type_o,
               left_in_precision_o, left_in_data_o, busy_o, done_o
    );

    modport slave (
        input  cmd_valid_i, cmd_len_i, cmd_type_i, cmd_precision_i, in_valid_i, in_data_i,
        output cmd_ready_o, in_ready_o, left_in_valid_o, left_in_cnt_o, left_in_type_o,
               left_in_precision_o, left_in_data_o, busy_o, done_o
    );
endinterface

// File: rtl/sarray_left_feeder.sv
// sarray_left_feeder: diagonally skews column beats of a tile onto the left edge of the systolic array
// clk, rst (async active-high); bus.slave carries cmd/in handshakes, left_in_* lanes, busy_o, done_o.
module sarray_left_feeder #(
    parameter int H      = 64,
    parameter int DW     = 16,
    parameter int CNT_W  = 8,
    parameter int PREC_W = 2
) (
    input logic clk,
    input logic rst,
    sarray_left_feeder_if.slave bus
);
    localparam int FW = $clog2(H + 1);

    typedef enum logic [1:0] {IDLE, STREAM, EMPTY, FLUSH} state_t;

    state_t            state;
    logic [CNT_W-1:0]  len_q;
    logic [CNT_W-1:0]  beat_idx;
    logic              type_q;
    logic [PREC_W-1:0] prec_q;
    logic [FW-1:0]     flush_cnt;
    logic              acc;

    assign acc             = (state == STREAM) && bus.in_valid_i;
    assign bus.cmd_ready_o = state == IDLE;
    assign bus.in_ready_o  = state == STREAM;
    assign bus.busy_o      = state != IDLE;
    assign bus.done_o      = (state == EMPTY) || (state == FLUSH && flush_cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            len_q     <= '0;
            beat_idx  <= '0;
            type_q    <= 1'b0;
            prec_q    <= '0;
            flush_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (bus.cmd_valid_i) begin
                    len_q    <= bus.cmd_len_i;
                    type_q   <= bus.cmd_type_i;
                    prec_q   <= bus.cmd_precision_i;
                    beat_idx <= '0;
                    state    <= bus.cmd_len_i == '0 ? EMPTY : STREAM;
                end
                STREAM: if (bus.in_valid_i) begin
                    if (beat_idx == len_q - CNT_W'(1)) begin
                        state     <= FLUSH;
                        flush_cnt <= FW'(H - 1);
                    end else begin
                        beat_idx <= beat_idx + CNT_W'(1);
                    end
                end
                EMPTY: state <= IDLE;
                FLUSH: begin
                    if (flush_cnt == '0) state <= IDLE;
                    else flush_cnt <= flush_cnt - FW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Control fields are identical on every lane, so one H-deep chain serves all lanes;
    // lane r taps stage r. Bubbles inject zeros so invalid slots read 0.
    logic              cv [H];
    logic [CNT_W-1:0]  cc [H];
    logic              ct [H];
    logic [PREC_W-1:0] cp [H];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < H; k++) begin
                cv[k] <= 1'b0;
                cc[k] <= '0;
                ct[k] <= 1'b0;
                cp[k] <= '0;
            end
        end else begin
            cv[0] <= acc;
            cc[0] <= acc ? beat_idx : '0;
            ct[0] <= acc & type_q;
            cp[0] <= acc ? prec_q : '0;
            for (int k = 1; k < H; k++) begin
                cv[k] <= cv[k-1];
                cc[k] <= cc[k-1];
                ct[k] <= ct[k-1];
                cp[k] <= cp[k-1];
            end
        end
    end

    // Data differs per lane, so each lane owns its own r+1 stage delay line.
    for (genvar r = 0; r < H; r++) begin : g_lane
        logic [DW-1:0] sr [r+1];
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int k = 0; k <= r; k++) sr[k] <= '0;
            end else begin
                sr[0] <= acc ? bus.in_data_i[r*DW +: DW] : '0;
                for (int k = 1; k <= r; k++) sr[k] <= sr[k-1];
            end
        end
        assign bus.left_in_data_o[r*DW +: DW]              = sr[r];
        assign bus.left_in_valid_o[r]                      = cv[r];
        assign bus.left_in_cnt_o[r*CNT_W +: CNT_W]         = cc[r];
        assign bus.left_in_type_o[r]                       = ct[r];
        assign bus.left_in_precision_o[r*PREC_W +: PREC_W] = cp[r];
    end
endmodule

// File: tb/tb_sarray_left_feeder.sv
// tb_sarray_left_feeder: scoreboard bench for sarray_left_feeder with H=4
module tb_sarray_left_feeder;
    localparam int H = 4, DW = 16, CNT_W = 8, PREC_W = 2;

    typedef struct packed {
        logic [15:0]       c;
        logic [CNT_W-1:0]  cnt;
        logic              t;
        logic [PREC_W-1:0] p;
        logic [DW-1:0]     d;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t lq [H][$];
    int   dq [$];
    logic idle_next = 1'b0;

    int              tile = 0;
    int              cur_beat = 0;
    logic [CNT_W-1:0] cur_len = '0;
    logic            cur_t = 1'b0;
    logic [1:0]      cur_p = '0;

    sarray_left_feeder_if #(.H(H), .DW(DW), .CNT_W(CNT_W), .PREC_W(PREC_W)) bus ();

    sarray_left_feeder #(.H(H), .DW(DW), .CNT_W(CNT_W), .PREC_W(PREC_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Monitor: pops per-lane expectations whenever a lane is valid; idle lanes must read zero.
    always @(negedge clk) begin
        exp_t e, a;
        for (int r = 0; r < H; r++) begin
            a = '{c: 16'(cyc),
                  cnt: bus.left_in_cnt_o[r*CNT_W +: CNT_W],
                  t: bus.left_in_type_o[r],
                  p: bus.left_in_precision_o[r*PREC_W +: PREC_W],
                  d: bus.left_in_data_o[r*DW +: DW]};
            if (bus.left_in_valid_o[r]) begin
                if (lq[r].size() == 0) chk($sformatf("lane%0d_unexpected", r), 64'(a), 64'h0);
                else begin
                    e = lq[r].pop_front();
                    chk($sformatf("lane%0d_beat", r), 64'(a), 64'(e));
                end
            end else begin
                chk($sformatf("lane%0d_idle", r), 64'({a.cnt, a.t, a.p, a.d}), 64'h0);
            end
        end
        if (idle_next) begin
            chk("idle_after_done", {62'h0, bus.cmd_ready_o, bus.busy_o}, 64'h2);
            idle_next = 1'b0;
        end
        if (bus.done_o) begin
            if (dq.size() == 0) chk("done_unexpected", 64'(cyc), 64'hFFFF);
            else chk("done_cycle", 64'(cyc), 64'(dq.pop_front()));
            chk("done_cmd_ready", 64'(bus.cmd_ready_o), 64'h0);
            idle_next = 1'b1;
        end
    end

    task automatic send_cmd(input logic [CNT_W-1:0] len, input logic typ, input logic [1:0] prec);
        int n = 0;
        bus.cmd_valid_i     = 1'b1;
        bus.cmd_len_i       = len;
        bus.cmd_type_i      = typ;
        bus.cmd_precision_i = prec;
        while (!bus.cmd_ready_o && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("cmd_ready_wait", 64'(bus.cmd_ready_o), 64'h1);
        tile++;
        cur_beat = 0;
        cur_len  = len;
        cur_t    = typ;
        cur_p    = prec;
        if (len == 0) dq.push_back(cyc + 1);
        @(posedge clk); #1;
        bus.cmd_valid_i     = 1'b0;
        bus.cmd_len_i       = '1;
        bus.cmd_type_i      = ~typ;
        bus.cmd_precision_i = ~prec;
    endtask

    task automatic send_beat();
        int n = 0;
        logic [H*DW-1:0] dat;
        for (int r = 0; r < H; r++) dat[r*DW +: DW] = 16'(tile * 256 + cur_beat * 16 + r);
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = dat;
        while (!bus.in_ready_o && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("in_ready_wait", 64'(bus.in_ready_o), 64'h1);
        for (int r = 0; r < H; r++)
            lq[r].push_back('{c: 16'(cyc + 1 + r), cnt: CNT_W'(cur_beat), t: cur_t, p: cur_p,
                              d: dat[r*DW +: DW]});
        cur_beat++;
        if (cur_beat == int'(cur_len)) dq.push_back(cyc + H);
        @(posedge clk); #1;
        bus.in_valid_i = 1'b0;
        bus.in_data_i  = '1;
    endtask

    task automatic bubble();
        bus.in_valid_i = 1'b0;
        bus.in_data_i  = '1;
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int pend;
        bus.cmd_valid_i     = 1'b0;
        bus.cmd_len_i       = '0;
        bus.cmd_type_i      = 1'b0;
        bus.cmd_precision_i = '0;
        bus.in_valid_i      = 1'b0;
        bus.in_data_i       = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_lanes", {bus.left_in_valid_o, bus.left_in_type_o}, 64'h0);
        chk("reset_wide", 64'(bus.left_in_data_o | 64'(bus.left_in_cnt_o) | 64'(bus.left_in_precision_o)), 64'h0);
        chk("reset_status", {60'h0, bus.cmd_ready_o, bus.in_ready_o, bus.busy_o, bus.done_o}, 64'h8);
        @(posedge clk); #1;

        send_cmd(3, 1'b0, 2'd1);
        repeat (3) send_beat();

        send_cmd(3, 1'b1, 2'd2);
        send_beat();
        bubble();
        send_beat();
        send_beat();

        send_cmd(0, 1'b0, 2'd0);
        repeat (3) @(posedge clk);
        #1;

        send_cmd(3, 1'b1, 2'd3);
        send_beat();
        bus.in_valid_i = 1'b1;
        rst = 1'b1;
        #1;
        chk("midreset_lanes", {bus.left_in_valid_o, bus.left_in_type_o}, 64'h0);
        chk("midreset_wide", 64'(bus.left_in_data_o | 64'(bus.left_in_cnt_o)), 64'h0);
        chk("midreset_status", {60'h0, bus.cmd_ready_o, bus.in_ready_o, bus.busy_o, bus.done_o}, 64'h8);
        for (int r = 0; r < H; r++) lq[r].delete();
        dq.delete();
        bus.in_valid_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        send_cmd(2, 1'b1, 2'd3);
        send_beat();
        send_beat();

        repeat (H + 4) @(posedge clk);
        pend = dq.size();
        for (int r = 0; r < H; r++) pend += lq[r].size();
        chk("drained", 64'(pend), 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
